// File: rtl/bkd2ibuf_ring_if.sv
// AXI-Stream ingress bundle for bkd2ibuf_ring: payload, strobes, 128-bit sideband and handshake.
interface bkd2ibuf_ring_if #(
  parameter int DW = 64
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic [127:0]    tuser;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/bkd2ibuf_ring.sv
// Backend-to-ibuf ring writer: packets land as header [+ timestamp] + payload in a 2^BW-word ring.
// Optional macro BKD2IBUF_RING_TIMESTAMP_EN adds a timestamp slot after each header.
module bkd2ibuf_ring #(
  parameter int BW           = 10,
  parameter int DW           = 64,
  parameter int MAX_WORDS    = 1024,
  parameter int DROP_ON_FULL = 0
) (
  input  logic          clk,
  input  logic          rst,
  bkd2ibuf_ring_if.slave s_axis,
  output logic          wr_en,
  output logic [BW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic          hst_rdy,
  output logic          activity,
  output logic [BW:0]   committed_prod,
  input  logic [BW:0]   committed_cons,
  output logic [31:0]   drop_cnt,
  output logic [31:0]   pkt_cnt
);

`ifdef BKD2IBUF_RING_TIMESTAMP_EN
  localparam int HL = 2;
`else
  localparam int HL = 1;
`endif
  localparam int CW = $clog2(MAX_WORDS + 1) + 1;
  localparam logic [BW:0]   HL_P  = (BW+1)'(HL);
  localparam logic [BW:0]   ONE_P = (BW+1)'(1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WORDS);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_WAIT,
    ST_DATA,
    ST_DROP,
    ST_HDR,
`ifdef BKD2IBUF_RING_TIMESTAMP_EN
    ST_TS,
`endif
    ST_CHK
  } state_t;

  state_t        state_q, state_d;
  logic [BW:0]   ax_q, ax_d;
  logic [BW:0]   prod_q, prod_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    src_q, src_d;
  logic [7:0]    dst_q, dst_d;
  logic          wr_en_q, wr_en_d;
  logic [BW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [31:0]   drop_q, drop_d;
  logic [31:0]   pkt_q, pkt_d;
  logic          hst_meta_q, hst_sync_q;
  logic [BW:0]   used;
  logic          full;
  logic          tready;
  logic          drop_full;
  logic          over;
  logic          end_drop;
  logic [DW-1:0] hdr_word;
`ifdef BKD2IBUF_RING_TIMESTAMP_EN
  logic [63:0]   ts_q, ts_d;
  logic [BW:0]   ts_ptr;
  logic [DW-1:0] ts_word;
`endif

  // Right after a commit that exactly fills the ring, ax already sits past the
  // reserved header slot, so anything at or above 2^BW counts as full.
  assign used = ax_q - committed_cons;
  assign full = used[BW];

  assign drop_full = (DROP_ON_FULL != 0) && s_axis.tvalid && full;
  assign over      = (beat_q >= MAX_C);

  always_comb begin
    hdr_word       = '0;
    hdr_word[63:0] = {16'h0, len_q, 8'h0, dst_q, 8'h0, src_q};
  end

`ifdef BKD2IBUF_RING_TIMESTAMP_EN
  assign ts_ptr = prod_q + ONE_P;
  always_comb begin
    ts_word       = '0;
    ts_word[63:0] = ts_q;
  end
  logic unused_bits;
  assign unused_bits = ^{s_axis.tstrb, s_axis.tuser[127:96]};
`else
  logic unused_bits;
  assign unused_bits = ^{s_axis.tstrb, s_axis.tuser[127:32]};
`endif

  always_comb begin
    state_d   = state_q;
    ax_d      = ax_q;
    prod_d    = prod_q;
    beat_d    = beat_q;
    len_d     = len_q;
    src_d     = src_q;
    dst_d     = dst_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    drop_d    = drop_q;
    pkt_d     = pkt_q;
    tready    = 1'b0;
    end_drop  = 1'b0;
`ifdef BKD2IBUF_RING_TIMESTAMP_EN
    ts_d      = ts_q;
`endif
    case (state_q)
      ST_INIT: begin
        prod_d  = '0;
        ax_d    = HL_P;
        beat_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (hst_sync_q) begin
          ax_d    = prod_q + HL_P;
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tready = (DROP_ON_FULL != 0) ? 1'b1 : ~full;
        if (s_axis.tvalid && tready) begin
          if (drop_full || over) begin
            state_d  = ST_DROP;
            end_drop = s_axis.tlast;
          end else begin
            if (beat_q == '0) begin
              len_d = s_axis.tuser[15:0];
              src_d = s_axis.tuser[23:16];
              dst_d = s_axis.tuser[31:24];
`ifdef BKD2IBUF_RING_TIMESTAMP_EN
              ts_d  = s_axis.tuser[95:32];
`endif
            end
            wr_en_d   = 1'b1;
            wr_addr_d = ax_q[BW-1:0];
            wr_data_d = s_axis.tdata;
            ax_d      = ax_q + ONE_P;
            beat_d    = beat_q + ONE_C;
            if (s_axis.tlast) state_d = ST_HDR;
          end
        end
      end
      ST_DROP: begin
        tready   = 1'b1;
        end_drop = s_axis.tvalid && s_axis.tlast;
      end
      ST_HDR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = prod_q[BW-1:0];
        wr_data_d = hdr_word;
`ifdef BKD2IBUF_RING_TIMESTAMP_EN
        state_d   = ST_TS;
      end
      ST_TS: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ts_ptr[BW-1:0];
        wr_data_d = ts_word;
`endif
        prod_d    = ax_q;
        pkt_d     = pkt_q + 32'd1;
        state_d   = ST_CHK;
      end
      ST_CHK: begin
        if (!hst_sync_q) begin
          state_d = ST_INIT;
        end else begin
          ax_d    = prod_q + HL_P;
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // A dropped packet rewinds ax to the slot just past its reserved header.
    if (end_drop) begin
      ax_d    = prod_q + HL_P;
      beat_d  = '0;
      drop_d  = (drop_q == 32'hFFFF_FFFF) ? drop_q : drop_q + 32'd1;
      state_d = hst_sync_q ? ST_DATA : ST_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      ax_q       <= '0;
      prod_q     <= '0;
      beat_q     <= '0;
      len_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      drop_q     <= '0;
      pkt_q      <= '0;
      hst_meta_q <= 1'b0;
      hst_sync_q <= 1'b0;
`ifdef BKD2IBUF_RING_TIMESTAMP_EN
      ts_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ax_q       <= ax_d;
      prod_q     <= prod_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      drop_q     <= drop_d;
      pkt_q      <= pkt_d;
      hst_meta_q <= hst_rdy;
      hst_sync_q <= hst_meta_q;
`ifdef BKD2IBUF_RING_TIMESTAMP_EN
      ts_q       <= ts_d;
`endif
    end
  end

  assign s_axis.tready  = tready;
  assign wr_en          = wr_en_q;
  assign activity       = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign committed_prod = prod_q;
  assign drop_cnt       = drop_q;
  assign pkt_cnt        = pkt_q;

endmodule

// File: tb/tb_bkd2ibuf_ring.sv
// Directed bench for bkd2ibuf_ring: two instances (backpressure / drop-on-full with MAX_WORDS=4)
// share one stimulus bus; sel picks which instance sees tvalid and whose outputs are checked.
module tb_bkd2ibuf_ring;
  localparam int BW = 4;
  localparam int DW = 64;
`ifdef BKD2IBUF_RING_TIMESTAMP_EN
  localparam int HL = 2;
`else
  localparam int HL = 1;
`endif
  localparam logic [63:0] TS = 64'hDEAD_BEEF_0000_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, hst_rdy, sel, tvalid, tlast;
  logic [63:0]   tdata;
  logic [127:0]  tuser;
  logic [BW:0]   cons0, cons1;
  int            n_err = 0;
  int            n_chk = 0;

  bkd2ibuf_ring_if #(.DW(DW)) s0 ();
  bkd2ibuf_ring_if #(.DW(DW)) s1 ();
  assign s0.tdata  = tdata;
  assign s0.tstrb  = '1;
  assign s0.tuser  = tuser;
  assign s0.tlast  = tlast;
  assign s0.tvalid = tvalid & ~sel;
  assign s1.tdata  = tdata;
  assign s1.tstrb  = '1;
  assign s1.tuser  = tuser;
  assign s1.tlast  = tlast;
  assign s1.tvalid = tvalid & sel;

  logic          wr_en0, wr_en1, act0, act1;
  logic [BW-1:0] wr_addr0, wr_addr1;
  logic [DW-1:0] wr_data0, wr_data1;
  logic [BW:0]   prod0, prod1;
  logic [31:0]   drop0, drop1, pkt0, pkt1;

  bkd2ibuf_ring #(.BW(BW), .DW(DW), .MAX_WORDS(32), .DROP_ON_FULL(0)) u_bp (
    .clk(clk), .rst(rst), .s_axis(s0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .hst_rdy(hst_rdy), .activity(act0), .committed_prod(prod0), .committed_cons(cons0),
    .drop_cnt(drop0), .pkt_cnt(pkt0));

  bkd2ibuf_ring #(.BW(BW), .DW(DW), .MAX_WORDS(4), .DROP_ON_FULL(1)) u_df (
    .clk(clk), .rst(rst), .s_axis(s1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .hst_rdy(hst_rdy), .activity(act1), .committed_prod(prod1), .committed_cons(cons1),
    .drop_cnt(drop1), .pkt_cnt(pkt1));

  logic          tready_m, wr_en_m, act_m;
  logic [BW-1:0] wr_addr_m;
  logic [63:0]   wr_data_m;
  logic [BW:0]   prod_m;
  logic [31:0]   drop_m, pkt_m;
  assign tready_m  = sel ? s1.tready : s0.tready;
  assign wr_en_m   = sel ? wr_en1 : wr_en0;
  assign act_m     = sel ? act1 : act0;
  assign wr_addr_m = sel ? wr_addr1 : wr_addr0;
  assign wr_data_m = sel ? wr_data1 : wr_data0;
  assign prod_m    = sel ? prod1 : prod0;
  assign drop_m    = sel ? drop1 : drop0;
  assign pkt_m     = sel ? pkt1 : pkt0;

  logic [BW-1:0] log_addr[$];
  logic [63:0]   log_data[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en_m === 1'b1) begin
      log_addr.push_back(wr_addr_m);
      log_data.push_back(wr_data_m);
      chk("activity", 64'(act_m), 64'd1);
      $display("write addr=%0d data=%h", wr_addr_m, wr_data_m);
    end
  end

  function automatic logic [63:0] hdr(input logic [15:0] len, input logic [7:0] src, input logic [7:0] dst);
    return {16'h0, len, 8'h0, dst, 8'h0, src};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    int cyc;
    tdata = d; tlast = last; tvalid = 1'b1; cyc = 0;
    while (1) begin
      @(negedge clk);
      if (tready_m) break;
      cyc++;
      if (cyc > 100) begin
        chk("beat_timeout", 64'(cyc), 64'd100);
        break;
      end
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic set_user(input logic [15:0] len, input logic [7:0] src, input logic [7:0] dst);
    tuser = {32'h0, TS, dst, src, len};
  endtask

  task automatic send_pkt(input int n, input logic [15:0] len, input logic [7:0] src,
                          input logic [7:0] dst, input logic [63:0] d0);
    set_user(len, src, dst);
    for (int i = 0; i < n; i++) send_beat(d0 + 64'(i), i == n - 1);
  endtask

  task automatic check_pkt(input string tag, input logic [BW:0] base, input int n,
                           input logic [63:0] hword, input logic [63:0] d0);
    logic [BW:0] p;
    chk({tag, "_nwr"}, 64'(log_addr.size()), 64'(n + HL));
    if (log_addr.size() != n + HL) begin
      log_addr.delete(); log_data.delete();
      return;
    end
    for (int i = 0; i < n; i++) begin
      p = base + (BW+1)'(HL + i);
      chk({tag, "_paddr"}, 64'(log_addr.pop_front()), 64'(p[BW-1:0]));
      chk({tag, "_pdata"}, log_data.pop_front(), d0 + 64'(i));
    end
    chk({tag, "_haddr"}, 64'(log_addr.pop_front()), 64'(base[BW-1:0]));
    chk({tag, "_hdata"}, log_data.pop_front(), hword);
`ifdef BKD2IBUF_RING_TIMESTAMP_EN
    p = base + (BW+1)'(1);
    chk({tag, "_taddr"}, 64'(log_addr.pop_front()), 64'(p[BW-1:0]));
    chk({tag, "_tdata"}, log_data.pop_front(), TS);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW:0] p;
    rst = 1'b1; hst_rdy = 1'b0; sel = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    tdata = '0; tuser = '0; cons0 = '0; cons1 = '0;
    idle(3);
    chk("rst_wr_en", 64'(wr_en0), 64'd0);
    chk("rst_prod", 64'(prod0), 64'd0);
    chk("rst_cnts", {drop0, pkt0}, 64'd0);
    chk("rst_wdata", wr_data0, 64'd0);
    chk("rst_tready", 64'(tready_m), 64'd0);
    rst = 1'b0; hst_rdy = 1'b1;
    idle(6);

    // Bring-up: 3 beats, header literal from the hand calculation
    send_pkt(3, 16'd24, 8'd1, 8'd2, 64'h100);
    idle(5);
    check_pkt("bringup", '0, 3, 64'h0000_0018_0002_0001, 64'h100);
    p = (BW+1)'(3 + HL);
    chk("bringup_prod", 64'(prod_m), 64'(p));
    chk("bringup_pkt", 64'(pkt_m), 64'd1);
    cons0 = p;

    // Wrap: consumer keeps up, three 5-beat packets
    for (int k = 0; k < 3; k++) begin
      send_pkt(5, 16'd40, 8'd3, 8'd4, 64'h200 + 64'(16 * k));
      idle(5);
      check_pkt("wrap", p, 5, hdr(16'd40, 8'd3, 8'd4), 64'h200 + 64'(16 * k));
      p = p + (BW+1)'(5 + HL);
      chk("wrap_prod", 64'(prod_m), 64'(p));
      cons0 = p;
    end
    chk("wrap_flag", 64'(prod_m[BW]), 64'd1);
    chk("wrap_pkt", 64'(pkt_m), 64'd4);

    // Backpressure: consumer frozen, 20-beat packet stalls once the ring fills
    set_user(16'd160, 8'd5, 8'd6);
    for (int i = 0; i < 20; i++) begin
      if (i == 16 - HL) begin
        idle(3);
        chk("bp_stall_tready", 64'(tready_m), 64'd0);
        chk("bp_written", 64'(log_addr.size()), 64'(16 - HL));
        chk("bp_prod_hold", 64'(prod_m), 64'(p));
        cons0 = p + (BW+1)'(8);
      end
      send_beat(64'h400 + 64'(i), i == 19);
    end
    idle(5);
    check_pkt("bp", p, 20, hdr(16'd160, 8'd5, 8'd6), 64'h400);
    p = p + (BW+1)'(20 + HL);
    chk("bp_prod", 64'(prod_m), 64'(p));
    chk("bp_pkt", 64'(pkt_m), 64'd5);
    cons0 = p;

    // Host-ready loss mid-packet: packet still commits, then the writer re-initialises
    set_user(16'd24, 8'd11, 8'd12);
    send_beat(64'h700, 1'b0);
    hst_rdy = 1'b0;
    send_beat(64'h701, 1'b0);
    send_beat(64'h702, 1'b1);
    idle(8);
    check_pkt("hl", p, 3, hdr(16'd24, 8'd11, 8'd12), 64'h700);
    chk("hl_pkt", 64'(pkt_m), 64'd6);
    chk("hl_prod_reinit", 64'(prod_m), 64'd0);
    chk("hl_tready", 64'(tready_m), 64'd0);
    cons0 = '0;
    hst_rdy = 1'b1;
    idle(6);

    // Oversize on the MAX_WORDS=4 instance
    sel = 1'b1; cons1 = '0;
    log_addr.delete(); log_data.delete();
    send_pkt(6, 16'd48, 8'd7, 8'd8, 64'h300);
    idle(5);
    chk("ovs_nwr", 64'(log_addr.size()), 64'd4);
    for (int i = 0; i < 4 && log_addr.size() > 0; i++) begin
      chk("ovs_addr", 64'(log_addr.pop_front()), 64'(HL + i));
      chk("ovs_data", log_data.pop_front(), 64'h300 + 64'(i));
    end
    chk("ovs_drop", 64'(drop_m), 64'd1);
    chk("ovs_prod", 64'(prod_m), 64'd0);
    chk("ovs_pkt", 64'(pkt_m), 64'd0);

    // Drop on full: 14 words already outstanding, so two beats fit
    log_addr.delete(); log_data.delete();
    cons1 = (BW+1)'(HL + 18);
    send_pkt(4, 16'd32, 8'd9, 8'd10, 64'h500);
    idle(5);
    chk("dof_nwr", 64'(log_addr.size()), 64'd2);
    for (int i = 0; i < 2 && log_addr.size() > 0; i++) begin
      chk("dof_addr", 64'(log_addr.pop_front()), 64'(HL + i));
      chk("dof_data", log_data.pop_front(), 64'h500 + 64'(i));
    end
    chk("dof_drop", 64'(drop_m), 64'd2);
    chk("dof_prod", 64'(prod_m), 64'd0);
    log_addr.delete(); log_data.delete();
    cons1 = '0;
    send_pkt(2, 16'd16, 8'd13, 8'd14, 64'h580);
    idle(5);
    check_pkt("dof_next", '0, 2, hdr(16'd16, 8'd13, 8'd14), 64'h580);
    chk("dof_next_prod", 64'(prod_m), 64'(2 + HL));
    chk("dof_next_pkt", 64'(pkt_m), 64'd1);

    // Asynchronous reset in the middle of a packet
    cons1 = (BW+1)'(2 + HL);
    set_user(16'd24, 8'd15, 8'd16);
    send_beat(64'h600, 1'b0);
    idle(2);
    log_addr.delete(); log_data.delete();
    #2 rst = 1'b1;
    #1;
    chk("arst_wr_en", 64'(wr_en_m), 64'd0);
    chk("arst_prod", 64'(prod_m), 64'd0);
    chk("arst_cnts", {drop_m, pkt_m}, 64'd0);
    chk("arst_tready", 64'(tready_m), 64'd0);
    chk("arst_waddr", 64'(wr_addr_m), 64'd0);
    idle(2);
    rst = 1'b0;
    cons1 = '0;
    idle(8);
    chk("arst_nocommit_prod", 64'(prod_m), 64'd0);
    chk("arst_nocommit_pkt", 64'(pkt_m), 64'd0);
    chk("arst_nowrite", 64'(log_addr.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
